// File: rtl/sevseg_avmm_ctrl.sv
// ---------------------------------------------------------------------------
// sevseg_avmm_ctrl
//
// Avalon-MM slave driving one seven-segment digit. Software picks either a
// hex digit (decoded here) or a raw segment pattern. The digit's brightness is
// set by a 16-step PWM duty. An optional blink gates the display on and off
// with a programmable half-period.
//
// Register map (word addresses):
//   0 DATA       [3:0]  hex digit                              reset 0x0
//   1 CTRL       [0] enable, [1] raw mode, [2] blink enable,
//                [11:8] PWM duty                               reset 0x0F01
//   2 RAW        [6:0]  segment pattern, 1 = lit               reset 0x00
//   3 BLINK_DIV  [25:0] blink half-period in clocks            reset 25_000_000
// Unused bits read as 0 and ignore writes.
//
// Ports:
//   clk        in   1   system clock
//   reset      in   1   synchronous, active-high
//   address    in   2   Avalon-MM word address
//   read       in   1   read strobe, fixed read latency of 1
//   write      in   1   write strobe, zero wait states
//   writedata  in  32   write data
//   readdata   out 32   read data, registered, held until the next read
//   seg_n      out  7   segment drive, active-low, [0]=a .. [6]=g
// ---------------------------------------------------------------------------
module sevseg_avmm_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [6:0]  seg_n
);

  localparam logic [1:0]  ADDR_DATA      = 2'd0;
  localparam logic [1:0]  ADDR_CTRL      = 2'd1;
  localparam logic [1:0]  ADDR_RAW       = 2'd2;
  localparam logic [1:0]  ADDR_BLINK_DIV = 2'd3;

  localparam logic [25:0] BLINK_DIV_RESET = 26'd25_000_000;
  localparam logic [3:0]  DUTY_RESET      = 4'hF;

  typedef enum logic {
    VISIBLE = 1'b0,
    BLANK   = 1'b1
  } blink_state_t;

  // Register file
  logic [3:0]  data_reg;
  logic        ctrl_enable;
  logic        ctrl_raw;
  logic        ctrl_blink;
  logic [3:0]  ctrl_duty;
  logic [6:0]  raw_reg;
  logic [25:0] blink_div;

  // Display timing state
  logic [3:0]   pwm_cnt;
  logic [25:0]  blink_cnt;
  logic [25:0]  blink_cnt_next;
  blink_state_t blink_state;
  blink_state_t blink_state_next;

  // Datapath
  logic [31:0] read_mux;
  logic [6:0]  hex_pattern;
  logic [6:0]  pattern;
  logic        pwm_on;
  logic        blanked;
  logic        show;
  logic        blink_restart;

  // Only the low 26 bits of a write ever land in a register.
  logic unused_writedata;
  assign unused_writedata = &{1'b0, writedata[31:26]};

  // -------------------------------------------------------------------------
  // Register writes
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg    <= 4'h0;
      ctrl_enable <= 1'b1;
      ctrl_raw    <= 1'b0;
      ctrl_blink  <= 1'b0;
      ctrl_duty   <= DUTY_RESET;
      raw_reg     <= 7'h00;
      blink_div   <= BLINK_DIV_RESET;
    end else if (write) begin
      case (address)
        ADDR_DATA: begin
          data_reg <= writedata[3:0];
        end
        ADDR_CTRL: begin
          ctrl_enable <= writedata[0];
          ctrl_raw    <= writedata[1];
          ctrl_blink  <= writedata[2];
          ctrl_duty   <= writedata[11:8];
        end
        ADDR_RAW: begin
          raw_reg <= writedata[6:0];
        end
        default: begin
          blink_div <= writedata[25:0];
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Read path. The mux sees register values from before this edge, so a
  // simultaneous read and write of the same address returns the old value.
  // -------------------------------------------------------------------------
  always_comb begin
    read_mux = 32'h0;
    case (address)
      ADDR_DATA:      read_mux = {28'h0, data_reg};
      ADDR_CTRL:      read_mux = {20'h0, ctrl_duty, 5'h0, ctrl_blink, ctrl_raw, ctrl_enable};
      ADDR_RAW:       read_mux = {25'h0, raw_reg};
      ADDR_BLINK_DIV: read_mux = {6'h0, blink_div};
      default:        read_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= 32'h0;
    end else if (read) begin
      readdata <= read_mux;
    end
  end

  // -------------------------------------------------------------------------
  // PWM: free-running 0..15; the digit is lit while the count is at or
  // below the duty, so duty 15 is always on and duty 0 is 1 cycle in 16.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt <= 4'h0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'h1;
    end
  end

  assign pwm_on = (pwm_cnt <= ctrl_duty);

  // -------------------------------------------------------------------------
  // Blink FSM. Reprogramming CTRL or BLINK_DIV restarts the half-period in
  // the visible phase. A divider of 0 or 1 parks the FSM in VISIBLE, which
  // also keeps the terminal-count compare away from the 0-1 underflow.
  // -------------------------------------------------------------------------
  assign blink_restart = write && ((address == ADDR_CTRL) || (address == ADDR_BLINK_DIV));

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_state <= VISIBLE;
      blink_cnt   <= 26'h0;
    end else begin
      blink_state <= blink_state_next;
      blink_cnt   <= blink_cnt_next;
    end
  end

  always_comb begin
    blink_state_next = blink_state;
    blink_cnt_next   = blink_cnt;
    if (blink_restart) begin
      blink_state_next = VISIBLE;
      blink_cnt_next   = 26'h0;
    end else if (blink_div < 26'd2) begin
      blink_state_next = VISIBLE;
      blink_cnt_next   = 26'h0;
    end else if (blink_cnt == (blink_div - 26'd1)) begin
      blink_cnt_next = 26'h0;
      case (blink_state)
        VISIBLE: blink_state_next = BLANK;
        BLANK:   blink_state_next = VISIBLE;
        default: blink_state_next = VISIBLE;
      endcase
    end else begin
      blink_cnt_next = blink_cnt + 26'd1;
    end
  end

  assign blanked = ctrl_blink && (blink_state == BLANK);

  // -------------------------------------------------------------------------
  // Hex decode, lit-high patterns in g..a order.
  // -------------------------------------------------------------------------
  always_comb begin
    hex_pattern = 7'h00;
    case (data_reg)
      4'h0: hex_pattern = 7'h3F;
      4'h1: hex_pattern = 7'h06;
      4'h2: hex_pattern = 7'h5B;
      4'h3: hex_pattern = 7'h4F;
      4'h4: hex_pattern = 7'h66;
      4'h5: hex_pattern = 7'h6D;
      4'h6: hex_pattern = 7'h7D;
      4'h7: hex_pattern = 7'h07;
      4'h8: hex_pattern = 7'h7F;
      4'h9: hex_pattern = 7'h6F;
      4'hA: hex_pattern = 7'h77;
      4'hB: hex_pattern = 7'h7C;
      4'hC: hex_pattern = 7'h39;
      4'hD: hex_pattern = 7'h5E;
      4'hE: hex_pattern = 7'h79;
      4'hF: hex_pattern = 7'h71;
      default: hex_pattern = 7'h00;
    endcase
  end

  assign pattern = ctrl_raw ? raw_reg : hex_pattern;
  assign show    = ctrl_enable && pwm_on && !blanked;

  // -------------------------------------------------------------------------
  // Segment output register, active-low. Registering here puts a register
  // write on the pins two edges after the write strobe.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_n <= 7'h7F;
    end else begin
      seg_n <= ~(pattern & {7{show}});
    end
  end

endmodule

// File: doc/sevseg_avmm_ctrl.md
SEVSEG_AVMM_CTRL -- requirements
Module: sevseg_avmm_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset (one clock; reset is synchronous and active-high).
REQ-002 The block SHALL have these ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- address  in  2  Avalon-MM word address
- read  in  1  read strobe
- write  in  1  write strobe
- writedata  in  32  write data
- readdata  out  32  read data, registered
- seg_n  out  7  segment drive, active-low, [0]=a..[6]=g; exported as the system's sevseg conduit
REQ-003 The block SHALL implement these registers (address, reset value, meaning):
- 0 DATA  0x0  [3:0] hex digit
- 1 CTRL  0x0F01  [0] enable, [1] raw mode, [2] blink enable, [11:8] duty
- 2 RAW  0x00  [6:0] segment pattern, 1 = lit
- 3 BLINK_DIV  25_000_000  [25:0] blink half-period in clocks
REQ-004 Unused register bits SHALL read 0 and ignore writes.

Function
REQ-005 A write SHALL update the addressed register on the clock edge where write=1; no waitrequest; zero wait states.
REQ-006 A read SHALL have fixed latency 1: readdata is valid on the edge after read=1 and holds its value until the next read.
REQ-007 When read and write are asserted together at the same address, readdata SHALL return the pre-write value.
REQ-008 The hex decode SHALL give lit patterns (g..a) 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
REQ-009 The pattern source SHALL be RAW[6:0] when CTRL[1]=1; otherwise it SHALL be decode(DATA[3:0]).
REQ-010 The PWM counter SHALL be a free-running 4-bit counter, 0..15, wrapping to 0.
REQ-011 pwm_on SHALL be 1 when pwm_cnt <= CTRL[11:8]:
- duty 15 = always on
- duty 0 = 1 cycle in 16
REQ-012 The blink counter SHALL count 0..BLINK_DIV-1; at terminal count it SHALL clear and toggle blink_phase.
REQ-013 The display SHALL be blanked when blink_phase=1 and CTRL[2]=1.
REQ-014 When BLINK_DIV=0 or 1, blink_phase SHALL stay 0 and the counter SHALL stay at 0.
REQ-015 Any write to BLINK_DIV or CTRL SHALL clear the blink counter and set blink_phase to 0 in the same edge.
REQ-016 seg_n SHALL be registered as ~(pattern & {7{enable & pwm_on & ~blanked}}).
REQ-017 The state machine SHALL be a 2-state blink FSM, VISIBLE <-> BLANK, toggled only by REQ-012 and forced to VISIBLE by REQ-015 or reset.
REQ-018 A register write SHALL be reflected on seg_n one clock after the register updates, i.e. 2 edges after the write strobe.
REQ-019 With CTRL[0]=0, seg_n SHALL be 7'h7F while the counters keep running.

Reset
REQ-020 When reset=1, the block SHALL on the next edge:
- load all registers to their REQ-003 values
- clear pwm_cnt, the blink counter and blink_phase
- set readdata=0 and seg_n=7'h7F
REQ-021 Reset asserted mid-blink or mid-read SHALL override all activity; any read pending in that cycle SHALL return 0.
REQ-022 After reset is released, seg_n SHALL show digit 0 (7'h40) at full duty from the second edge onward.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset, then read all 4 addresses -> 0x0, 0x0F01, 0x00, 0x17D7840; seg_n=7'h40.
- Write DATA=0xA; sample seg_n for 2 edges -> 7'h08 at edge 2, not before. Repeat for all 16 digits against REQ-008.
- Write RAW=0x49, then CTRL=0x0F03 -> seg_n=7'h36. Write CTRL=0x0F00 -> seg_n=7'h7F.
- Write CTRL=0x0301 -> seg_n lit for exactly 4 of every 16 cycles over 64 cycles.
- Write BLINK_DIV=4, then CTRL=0x0F05 -> 4 cycles lit, 4 blank, repeating. Write BLINK_DIV=0 -> steady lit.
- Same-cycle read+write at address 0 (old 0x3, new 0x7) -> readdata=0x3; next read -> 0x7. Assert reset during a blank phase -> seg_n=7'h7F, then 7'h40.
